// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter/sequencer.
package dmem_pkg;

  localparam int unsigned PORTS       = 2;
  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} dmem_state_t;

  // One latched request; widths follow the memory geometry above.
  typedef struct packed {
    logic                   we;
    logic                   wide;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } req_t;

  // Port index of a one-hot (or zero) two-port grant vector.
  function automatic logic grant_id(input logic [PORTS-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-input arbiter: round-robin on ties when RR_EN, otherwise port 0 always wins.
module dmem_rr_arb import dmem_pkg::*; #(
  parameter bit RR_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_en,
  input  logic [PORTS-1:0] i_req,
  output logic [PORTS-1:0] o_grant
);

  // Port favoured on the next tie; 0 after reset so port 0 wins the first tie.
  logic             r_prio;
  logic [PORTS-1:0] w_grant;

  // Grant decode; nothing is granted while disabled or in reset.
  always_comb begin
    w_grant = '0;
    if (i_en && !Reset) begin
      unique case (i_req)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = (RR_EN && r_prio) ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign o_grant = w_grant;

  // Priority pointer: after each grant the other port is favoured.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prio <= 1'b0;
    end else if (|w_grant) begin
      r_prio <= w_grant[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Arbitrates two requesters onto a byte-wide memory and sequences wide accesses
// as a low-byte cycle followed by a high-byte cycle.
module dmem_arbiter_ctrl import dmem_pkg::*; #(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,  // must match the package req_t width
  parameter int unsigned DATA_W = DMEM_DATA_W,  // fixed at two bytes
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic              i_wide0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic              i_wide1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_done0,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_mem_write,
  output logic              o_mem_read,
  output logic              o_byte,
  output logic [ADDR_W-1:0] o_data_address,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out
);

  dmem_state_t       r_state, w_state_nxt;
  req_t              r_req;
  logic              r_owner;
  logic [DATA_W-1:0] r_rdata;

  logic [PORTS-1:0]  w_grant;
  logic              w_idle;
  logic [ADDR_W-1:0] w_addr_hi;
  req_t              w_req0, w_req1;

  assign w_idle    = (r_state == IDLE);
  assign w_addr_hi = r_req.addr + ADDR_W'(1);  // wraps 0xFF -> 0x00

  assign w_req0 = '{we: i_we0, wide: i_wide0, addr: i_addr0, wdata: i_wdata0};
  assign w_req1 = '{we: i_we1, wide: i_wide1, addr: i_addr1, wdata: i_wdata1};

  dmem_rr_arb #(
    .RR_EN (RR_EN)
  ) u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_en    (w_idle),
    .i_req   ({i_req1, i_req0}),
    .o_grant (w_grant)
  );

  assign o_ack0 = w_grant[0];
  assign o_ack1 = w_grant[1];
  assign o_busy = !Reset && !w_idle;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: IDLE -> LO -> (HI if wide) -> RESP -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (|w_grant) w_state_nxt = LO;
      LO:      w_state_nxt = r_req.wide ? HI : RESP;
      HI:      w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the granted request and assemble load data byte by byte.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_req   <= '0;
      r_owner <= 1'b0;
      r_rdata <= '0;
    end else if (|w_grant) begin
      r_owner <= grant_id(w_grant);
      r_req   <= w_grant[1] ? w_req1 : w_req0;
      r_rdata <= '0;  // byte loads and stores return zero in unused bytes
    end else if (r_state == LO && !r_req.we) begin
      r_rdata[7:0] <= i_mem_data_out[7:0];
    end else if (r_state == HI && !r_req.we) begin
      r_rdata[DATA_W-1:8] <= i_mem_data_out[DATA_W-1:8];
    end
  end

  // Memory strobes, completion pulse and read data, all quiet during reset.
  always_comb begin
    o_mem_write    = 1'b0;
    o_mem_read     = 1'b0;
    o_byte         = 1'b0;
    o_data_address = '0;
    o_mem_data_in  = '0;
    o_done0        = 1'b0;
    o_done1        = 1'b0;
    o_rdata        = '0;
    if (!Reset) begin
      unique case (r_state)
        LO: begin
          o_mem_write    = r_req.we;
          o_mem_read     = !r_req.we;
          o_data_address = r_req.addr;
          o_mem_data_in  = r_req.we ? r_req.wdata : '0;
        end
        HI: begin
          o_mem_write    = r_req.we;
          o_mem_read     = !r_req.we;
          o_byte         = 1'b1;
          o_data_address = w_addr_hi;
          o_mem_data_in  = r_req.we ? r_req.wdata : '0;
        end
        RESP: begin
          o_done0 = !r_owner;
          o_done1 = r_owner;
          o_rdata = r_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Directed bench: round-robin DUT with a memory model, plus a fixed-priority
// DUT sharing the same requester inputs for the arbitration-mode comparison.
module tb_dmem_arbiter_ctrl;

  logic        Clk, Reset;
  logic        req0, we0, wide0, req1, we1, wide1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic        ack0, ack1, done0, done1, busy, mem_write, mem_read, mem_byte;
  logic [15:0] rdata, mem_din, mem_dout;
  logic [7:0]  daddr;

  logic        fp_ack0, fp_ack1, fp_done0, fp_done1, fp_busy, fp_mw, fp_mr, fp_byte;
  logic [15:0] fp_rdata, fp_din;
  logic [7:0]  fp_daddr;

  logic [7:0]  core [256];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter_ctrl #(.ADDR_W(8), .DATA_W(16), .RR_EN(1'b1)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .i_req0(req0), .i_we0(we0), .i_wide0(wide0), .i_addr0(addr0), .i_wdata0(wdata0),
    .i_req1(req1), .i_we1(we1), .i_wide1(wide1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_done0(done0), .o_done1(done1), .o_rdata(rdata),
    .o_busy(busy), .o_mem_write(mem_write), .o_mem_read(mem_read), .o_byte(mem_byte),
    .o_data_address(daddr), .o_mem_data_in(mem_din), .i_mem_data_out(mem_dout)
  );

  dmem_arbiter_ctrl #(.ADDR_W(8), .DATA_W(16), .RR_EN(1'b0)) u_dut_fp (
    .Clk(Clk), .Reset(Reset),
    .i_req0(req0), .i_we0(we0), .i_wide0(wide0), .i_addr0(addr0), .i_wdata0(wdata0),
    .i_req1(req1), .i_we1(we1), .i_wide1(wide1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack0(fp_ack0), .o_ack1(fp_ack1), .o_done0(fp_done0), .o_done1(fp_done1),
    .o_rdata(fp_rdata), .o_busy(fp_busy), .o_mem_write(fp_mw), .o_mem_read(fp_mr),
    .o_byte(fp_byte), .o_data_address(fp_daddr), .o_mem_data_in(fp_din),
    .i_mem_data_out(16'h0000)
  );

  // Memory model: asynchronous read into the selected half, write on the clock edge.
  assign mem_dout = !mem_read ? 16'h0000 :
                    (mem_byte ? {core[daddr], 8'h00} : {8'h00, core[daddr]});

  always @(posedge Clk) begin
    if (mem_write) core[daddr] <= mem_byte ? mem_din[15:8] : mem_din[7:0];
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Runs one access on a port; reports read data, Ack-to-Done latency and completion.
  task automatic run_txn(input int port, input logic we, input logic wide,
                         input logic [7:0] addr, input logic [15:0] wdata,
                         output logic [15:0] rd, output int lat, output bit got);
    bit acked;
    rd = '0; lat = 0; got = 0; acked = 0;
    @(posedge Clk); #1;
    if (port == 0) begin
      req0 = 1; we0 = we; wide0 = wide; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1; we1 = we; wide1 = wide; addr1 = addr; wdata1 = wdata;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin acked = 1; break; end
    end
    @(posedge Clk); #1;
    req0 = 0; req1 = 0;
    if (!acked) return;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      lat++;
      if ((port == 0 && done0) || (port == 1 && done1)) begin rd = rdata; got = 1; break; end
    end
  endtask

  task automatic test_reset;
    Reset = 1; req0 = 1; req1 = 0; we0 = 1; wide0 = 1; addr0 = 8'h33; wdata0 = 16'h5555;
    we1 = 0; wide1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_tests++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if ({mem_write, mem_read} !== 2'b00) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 00", {mem_write, mem_read}); end
    n_tests++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    @(posedge Clk); #1;
    req0 = 0; Reset = 0;
    @(negedge Clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    n_tests++; if ({daddr, mem_din} !== 24'h0) begin
      n_fail++; $display("FAIL idle_bus: got %h want 000000", {daddr, mem_din}); end
  endtask

  task automatic test_wide_store_load;
    logic [15:0] rd; int lat; bit got;
    run_txn(0, 1, 1, 8'h10, 16'hBEEF, rd, lat, got);
    n_tests++; if (!got || lat != 3) begin n_fail++; $display("FAIL wst_latency: got %0d (done %b) want 3", lat, got); end
    n_tests++; if (core[8'h10] !== 8'hEF) begin n_fail++; $display("FAIL wst_lo: got %h want ef", core[8'h10]); end
    n_tests++; if (core[8'h11] !== 8'hBE) begin n_fail++; $display("FAIL wst_hi: got %h want be", core[8'h11]); end
    n_tests++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL wst_rdata: got %h want 0000", rd); end
    run_txn(0, 0, 1, 8'h10, 16'h0000, rd, lat, got);
    n_tests++; if (!got || lat != 3) begin n_fail++; $display("FAIL wld_latency: got %0d (done %b) want 3", lat, got); end
    n_tests++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL wld_rdata: got %h want beef", rd); end
  endtask

  task automatic test_byte_wrap;
    logic [15:0] rd; int lat; bit got;
    run_txn(1, 1, 0, 8'h20, 16'hC35A, rd, lat, got);
    n_tests++; if (!got || lat != 2) begin n_fail++; $display("FAIL bst_latency: got %0d (done %b) want 2", lat, got); end
    n_tests++; if (core[8'h20] !== 8'h5A) begin n_fail++; $display("FAIL bst_data: got %h want 5a", core[8'h20]); end
    run_txn(1, 0, 0, 8'h20, 16'h0000, rd, lat, got);
    n_tests++; if (!got || lat != 2) begin n_fail++; $display("FAIL bld_latency: got %0d (done %b) want 2", lat, got); end
    n_tests++; if (rd !== 16'h005A) begin n_fail++; $display("FAIL bld_rdata: got %h want 005a", rd); end
    run_txn(1, 1, 1, 8'hFF, 16'h1234, rd, lat, got);
    n_tests++; if (core[8'hFF] !== 8'h34) begin n_fail++; $display("FAIL wrap_lo: got %h want 34", core[8'hFF]); end
    n_tests++; if (core[8'h00] !== 8'h12) begin n_fail++; $display("FAIL wrap_hi: got %h want 12", core[8'h00]); end
  endtask

  task automatic test_tie;
    int rr_ack[16]; int rr_done[16]; int fp_ack[16];
    int n_ra = 0, n_rd = 0, n_fa = 0, fp_ack1_cnt = 0;
    bit got1 = 0;
    Reset = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0; wide0 = 0; wide1 = 0;
    addr0 = 8'h10; addr1 = 8'h20;
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      if (ack0) begin rr_ack[n_ra] = 0; n_ra++; end
      if (ack1) begin rr_ack[n_ra] = 1; n_ra++; end
      if (done0) begin rr_done[n_rd] = 0; n_rd++; end
      if (done1) begin rr_done[n_rd] = 1; n_rd++; end
      if (fp_ack0) begin fp_ack[n_fa] = 0; n_fa++; end
      if (fp_ack1) begin fp_ack[n_fa] = 1; n_fa++; fp_ack1_cnt++; end
    end
    n_tests++; if (n_ra < 4 || n_rd < 4 || n_fa < 4) begin
      n_fail++; $display("FAIL tie_counts: got acks %0d dones %0d fp %0d want >=4 each", n_ra, n_rd, n_fa);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++; if (rr_ack[k] != (k % 2)) begin
          n_fail++; $display("FAIL rr_ack_order[%0d]: got %0d want %0d", k, rr_ack[k], k % 2); end
        n_tests++; if (rr_done[k] != (k % 2)) begin
          n_fail++; $display("FAIL rr_done_order[%0d]: got %0d want %0d", k, rr_done[k], k % 2); end
      end
    end
    n_tests++; if (fp_ack1_cnt != 0) begin n_fail++; $display("FAIL fp_no_ack1: got %0d want 0", fp_ack1_cnt); end
    @(posedge Clk); #1;
    req0 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (fp_ack1) begin got1 = 1; break; end
    end
    n_tests++; if (!got1) begin n_fail++; $display("FAIL fp_ack1_after_drop: got 0 want 1"); end
    @(posedge Clk); #1;
    req1 = 0;
    repeat (6) @(posedge Clk);
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd; int lat; bit got, acked;
    logic [7:0] snap;
    acked = 0;
    run_txn(0, 1, 0, 8'h41, 16'h0033, rd, lat, got);
    snap = core[8'h41];
    @(posedge Clk); #1;
    req0 = 1; we0 = 1; wide0 = 1; addr0 = 8'h40; wdata0 = 16'hAAAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (ack0) begin acked = 1; break; end
    end
    n_tests++; if (!acked) begin n_fail++; $display("FAIL rm_ack: got 0 want 1"); end
    @(posedge Clk); #1;
    req0 = 0;
    @(negedge Clk);
    n_tests++; if ({mem_write, mem_byte, daddr} !== {1'b1, 1'b0, 8'h40}) begin
      n_fail++; $display("FAIL rm_lo_bus: got %h want 140", {mem_write, mem_byte, daddr}); end
    @(posedge Clk); #1;
    Reset = 1;
    @(negedge Clk);
    n_tests++; if ({mem_write, mem_read, busy, done0} !== 4'b0000) begin
      n_fail++; $display("FAIL rm_reset_outs: got %b want 0000", {mem_write, mem_read, busy, done0}); end
    @(posedge Clk); #1;
    Reset = 0;
    @(negedge Clk);
    n_tests++; if ({busy, done0, done1} !== 3'b000) begin
      n_fail++; $display("FAIL rm_after: got %b want 000", {busy, done0, done1}); end
    n_tests++; if (core[8'h40] !== 8'hAA) begin n_fail++; $display("FAIL rm_lo_byte: got %h want aa", core[8'h40]); end
    n_tests++; if (core[8'h41] !== snap) begin n_fail++; $display("FAIL rm_hi_byte: got %h want %h", core[8'h41], snap); end
    run_txn(0, 0, 0, 8'h40, 16'h0000, rd, lat, got);
    n_tests++; if (!got || lat != 2 || rd !== 16'h00AA) begin
      n_fail++; $display("FAIL rm_next: got %h lat %0d want 00aa lat 2", rd, lat); end
  endtask

  task automatic test_back_to_back;
    int t_done0 = -1, t_done1 = -1;
    bit acked = 0, early = 0, busy_low = 0;
    logic [15:0] rd0 = '0, rd1 = '0;
    @(posedge Clk); #1;
    req0 = 1; we0 = 0; wide0 = 1; addr0 = 8'h10;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (ack0) begin acked = 1; break; end
    end
    n_tests++; if (!acked) begin n_fail++; $display("FAIL b2b_ack0: got 0 want 1"); end
    @(posedge Clk); #1;
    req0 = 0; req1 = 1; we1 = 0; wide1 = 0; addr1 = 8'h20;
    for (int c = 1; c < 12; c++) begin
      @(negedge Clk);
      if (ack1 && t_done0 < 0) early = 1;
      if (c <= 3 && !busy) busy_low = 1;
      if (done0) begin t_done0 = c; rd0 = rdata; end
      if (done1) begin t_done1 = c; rd1 = rdata; end
      if (ack1) begin @(posedge Clk); #1; req1 = 0; c++; end
    end
    n_tests++; if (early) begin n_fail++; $display("FAIL b2b_ack1_early: got 1 want 0"); end
    n_tests++; if (busy_low) begin n_fail++; $display("FAIL b2b_busy: got low want high"); end
    n_tests++; if (t_done0 != 3) begin n_fail++; $display("FAIL b2b_done0_time: got %0d want 3", t_done0); end
    n_tests++; if (t_done1 < 0 || t_done1 - t_done0 < 3) begin
      n_fail++; $display("FAIL b2b_gap: got done1 at %0d want >= %0d", t_done1, t_done0 + 3); end
    n_tests++; if (rd0 !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_rd0: got %h want beef", rd0); end
    n_tests++; if (rd1 !== 16'h005A) begin n_fail++; $display("FAIL b2b_rd1: got %h want 005a", rd1); end
  endtask

  initial begin
    test_reset();
    test_wide_store_load();
    test_byte_wrap();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
